// File: rtl/ps2_key_source_if.sv
// Key stream bundle: PS/2 pins in, kv/kd/kr pop handshake and error pulses.
// The slave side is the keyboard front end, the master side drives the pins and kr.
interface ps2_key_source_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       kr;
    logic       kv;
    logic [7:0] kd;
    logic       frame_err;
    logic       ovf;

    modport master (
        output ps2_clk, ps2_data, kr,
        input  kv, kd, frame_err, ovf
    );

    modport slave (
        input  ps2_clk, ps2_data, kr,
        output kv, kd, frame_err, ovf
    );
endinterface

// File: rtl/ps2_key_source.sv
// PS/2 device-to-host receiver with frame checking, optional break stripping
// and a small scan-code FIFO exposed as the kv/kd/kr key stream.
module ps2_key_source #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 2000,
    parameter bit DROP_BREAK = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    ps2_key_source_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, RECV} state_t;

    state_t        state_q, state_d;
    logic          c_s1_q, c_s1_d, c_s2_q, c_s2_d, c_p_q, c_p_d;
    logic          d_s1_q, d_s1_d, d_s2_q, d_s2_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          push_q, push_d;
    logic [7:0]    pdata_q, pdata_d;
    logic          ferr_q, ferr_d;
    logic          ovf_q, ovf_d;
    logic          brk_q, brk_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic fall, din, good, pop, full, wr;

    assign fall = c_p_q & ~c_s2_q;
    assign din  = d_s2_q;
    assign full = (cnt_q == FULL_CNT);
    assign pop  = bus.kr & (cnt_q != '0);
    assign wr   = push_q & (~full | pop);

    always_comb begin
        c_s1_d  = bus.ps2_clk;
        c_s2_d  = c_s1_q;
        c_p_d   = c_s2_q;
        d_s1_d  = bus.ps2_data;
        d_s2_d  = d_s1_q;
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        to_d    = to_q;
        push_d  = 1'b0;
        pdata_d = pdata_q;
        ferr_d  = 1'b0;
        brk_d   = brk_q;
        good    = 1'b0;
        unique case (state_q)
            IDLE: begin
                to_d = '0;
                if (fall && !din) begin
                    state_d = RECV;
                    bit_d   = 4'd1;
                    sh_d    = '0;
                    par_d   = 1'b0;
                end
            end
            RECV: begin
                if (fall) begin
                    to_d = '0;
                    unique case (1'b1)
                        (bit_q <= 4'd8): begin
                            sh_d  = {din, sh_q[7:1]};
                            par_d = par_q ^ din;
                            bit_d = bit_q + 4'd1;
                        end
                        (bit_q == 4'd9): begin
                            par_d = par_q ^ din;
                            bit_d = 4'd10;
                        end
                        default: begin
                            state_d = IDLE;
                            bit_d   = 4'd0;
                            good    = din & par_q;
                            ferr_d  = ~good;
                        end
                    endcase
                end else if (to_q >= TO_LAST) begin
                    state_d = IDLE;
                    bit_d   = 4'd0;
                    to_d    = '0;
                    ferr_d  = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // E0 prefixes pass untouched; F0 arms a drop of the following byte.
        if (good) begin
            pdata_d = sh_q;
            if (!DROP_BREAK || sh_q == 8'hE0) begin
                push_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
            end else if (sh_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push_d = 1'b1;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        ovf_d = push_q & full & ~pop;
        if (wr) begin
            mem_d[wp_q] = pdata_q;
            wp_d        = wp_q + 1'b1;
        end
        if (pop) begin
            rp_d = rp_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(wr) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_s1_q  <= 1'b1;
            c_s2_q  <= 1'b1;
            c_p_q   <= 1'b1;
            d_s1_q  <= 1'b1;
            d_s2_q  <= 1'b1;
            state_q <= IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            to_q    <= '0;
            push_q  <= 1'b0;
            pdata_q <= '0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            brk_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            c_s1_q  <= c_s1_d;
            c_s2_q  <= c_s2_d;
            c_p_q   <= c_p_d;
            d_s1_q  <= d_s1_d;
            d_s2_q  <= d_s2_d;
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            to_q    <= to_d;
            push_q  <= push_d;
            pdata_q <= pdata_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
            brk_q   <= brk_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.kv        = (cnt_q != '0);
    assign bus.kd        = (cnt_q != '0) ? mem_q[rp_q] : 8'h00;
    assign bus.frame_err = ferr_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_ps2_key_source.sv
// Scoreboard bench: two DUTs share the PS/2 pins, one stripping breaks
// (popped by the bench) and one keeping every byte (always popping).
module tb_ps2_key_source;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pclk = 1'b1;
    logic pdat = 1'b1;
    logic kr0 = 1'b0;

    int tests = 0;
    int fails = 0;
    int fe0 = 0, fe1 = 0, ov0 = 0;
    int exp_fe = 0, exp_ov = 0;
    bit brk_m = 1'b0;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];

    always #5 clk = ~clk;

    ps2_key_source_if b0 ();
    ps2_key_source_if b1 ();

    assign b0.ps2_clk  = pclk;
    assign b0.ps2_data = pdat;
    assign b0.kr       = kr0;
    assign b1.ps2_clk  = pclk;
    assign b1.ps2_data = pdat;
    assign b1.kr       = 1'b1;

    ps2_key_source #(.FIFO_DEPTH(4), .TIMEOUT(2000), .DROP_BREAK(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    ps2_key_source #(.FIFO_DEPTH(4), .TIMEOUT(2000), .DROP_BREAK(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (b0.kv && b0.kr) begin
                tests++;
                if (exp0.size() == 0) begin
                    fails++;
                    $display("FAIL pop0: got 0x%0h expected nothing", b0.kd);
                end else begin
                    logic [7:0] e;
                    e = exp0.pop_front();
                    if (b0.kd !== e) begin
                        fails++;
                        $display("FAIL pop0: got 0x%0h expected 0x%0h", b0.kd, e);
                    end
                end
            end
            if (b1.kv) begin
                tests++;
                if (exp1.size() == 0) begin
                    fails++;
                    $display("FAIL pop1: got 0x%0h expected nothing", b1.kd);
                end else begin
                    logic [7:0] e;
                    e = exp1.pop_front();
                    if (b1.kd !== e) begin
                        fails++;
                        $display("FAIL pop1: got 0x%0h expected 0x%0h", b1.kd, e);
                    end
                end
            end
            if (b0.frame_err) fe0++;
            if (b1.frame_err) fe1++;
            if (b0.ovf) ov0++;
            if (b0.frame_err && b0.ovf) begin
                tests++;
                fails++;
                $display("FAIL err_ovf_overlap: got 1 expected 0");
            end
        end
    end

    // mode 1: check kv/kd 4 clk after stop edge; mode 2: pulse kr in the push cycle
    task automatic send(input logic [7:0] d, input int mode,
                        input bit bp, input bit bs, input int nbits);
        logic [10:0] bits;
        bits = {~bs, (~^d) ^ bp, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            pdat = bits[i];
            repeat (10) @(posedge clk);
            #1 pclk = 1'b0;
            if (i == 10) begin
                repeat (3) @(posedge clk);
                #1;
                if (mode == 2) kr0 = 1'b1;
                @(posedge clk);
                #1;
                kr0 = 1'b0;
                if (mode == 1) begin
                    check("latency_kv", b0.kv, 1);
                    check("latency_kd", b0.kd, d);
                end
                repeat (6) @(posedge clk);
            end else begin
                repeat (10) @(posedge clk);
            end
            #1 pclk = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1 pdat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int mode, input bit bp, input bit bs);
        bit push;
        if (bp || bs) begin
            exp_fe++;
        end else begin
            exp1.push_back(d);
            push = 1'b0;
            if (d == 8'hE0) push = 1'b1;
            else if (brk_m) brk_m = 1'b0;
            else if (d == 8'hF0) brk_m = 1'b1;
            else push = 1'b1;
            if (push) begin
                if (exp0.size() >= 4 && mode != 2) exp_ov++;
                else exp0.push_back(d);
            end
        end
        send(d, mode, bp, bs, 11);
    endtask

    task automatic pop0(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 kr0 = 1'b1;
            @(posedge clk);
            #1 kr0 = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_kv", b0.kv, 0);
        check("rst_kd", b0.kd, 0);
        check("rst_ferr", b0.frame_err, 0);
        check("rst_ovf", b0.ovf, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        send_byte(8'h1C, 1, 0, 0);
        pop0(1);
        check("t1_kv", b0.kv, 0);
        check("t1_kd", b0.kd, 0);

        send_byte(8'h1C, 0, 0, 0);
        send_byte(8'hF0, 0, 0, 0);
        send_byte(8'h1C, 0, 0, 0);
        send_byte(8'hE0, 0, 0, 0);
        check("t2_ferr", fe0, 0);
        check("t2_q0", exp0.size(), 2);
        pop0(2);
        check("t2_kv", b0.kv, 0);
        check("t2_q1", exp1.size(), 0);

        send_byte(8'h12, 0, 1, 0);
        send_byte(8'h12, 0, 0, 1);
        send(8'h12, 0, 0, 0, 5);
        repeat (2100) @(posedge clk);
        #1;
        exp_fe++;
        check("t3_fe0", fe0, exp_fe);
        check("t3_fe1", fe1, exp_fe);
        check("t3_kv", b0.kv, 0);
        send_byte(8'h12, 0, 0, 0);
        pop0(1);
        check("t3_kv2", b0.kv, 0);

        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0, 0, 0);
        check("t4_ovf", ov0, 1);
        check("t4_ovf_m", ov0, exp_ov);
        pop0(4);
        check("t4_kv", b0.kv, 0);
        check("t4_kd", b0.kd, 0);

        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0, 0, 0);
        send_byte(8'h05, 2, 0, 0);
        check("t5_ovf", ov0, 1);
        check("t5_q0", exp0.size(), 4);
        pop0(4);
        check("t5_kv", b0.kv, 0);

        send_byte(8'h41, 0, 0, 0);
        send_byte(8'h42, 0, 0, 0);
        check("t6_kv_pre", b0.kv, 1);
        send(8'h55, 0, 0, 0, 4);
        rst_n = 1'b0;
        #1;
        check("t6_kv", b0.kv, 0);
        check("t6_kd", b0.kd, 0);
        exp0.delete();
        exp1.delete();
        brk_m = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_byte(8'h33, 1, 0, 0);
        pop0(1);
        check("t6_kv2", b0.kv, 0);
        check("end_fe", fe0, exp_fe);
        check("end_q0", exp0.size(), 0);
        check("end_q1", exp1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_key_source.md
Name: ps2_key_source

Overview:
- Keyboard front end that produces the `kv`/`kd` key stream the `cpu` consumes.
- Deserialises PS/2 device-to-host frames, checks them, and optionally strips break (key-release) sequences.
- Buffers scan codes in a small FIFO. `kv` means "key byte available", `kd` is the oldest byte, and the CPU pops with `kr`.
- Sits between the board PS/2 pins and the `cpu` `kv`/`kd` inputs.

Parameters:
- FIFO_DEPTH, 4, number of buffered bytes; power of two, 2..16.
- TIMEOUT, 2000, `clk` cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.
- DROP_BREAK, 1, when 1 a received 0xF0 and the byte after it are discarded.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  PS/2 clock pin; asynchronous.
- ps2_data  in  1  PS/2 data pin; asynchronous.
- kr  in  1  key read: pops the head byte when kv=1.
- kv  out  1  key valid: FIFO non-empty.
- kd  out  8  head byte of the FIFO; 0x00 when kv=0.
- frame_err  out  1  one-cycle pulse on a bad frame (start, parity, stop or timeout).
- ovf  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset (async, rst_n=0):
  - kv=0, kd=0x00, frame_err=0, ovf=0.
  - FIFO empty, FSM IDLE, bit counter 0, break flag clear.
  - Synchroniser and previous-sample flops = 1.
- Input sampling:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - fall = (prev synced ps2_clk == 1) and (synced ps2_clk == 0).
  - Data is sampled from synced ps2_data in the fall cycle.
- IDLE:
  - On fall with data=0 (start bit): go to RECV, bit counter = 1, timeout counter cleared.
  - On fall with data=1: stay in IDLE, no error.
- RECV:
  - Bits 1..8 are data, shifted in LSB first.
  - Bit 9 is parity; it must make the 9-bit total (data + parity) odd.
  - Bit 10 is stop and must be 1.
  - On the stop-bit fall, go to IDLE. A good frame produces a push request next cycle; a bad parity or stop bit pulses frame_err instead.
  - The timeout counter increments every cycle in RECV and clears on each fall. On reaching TIMEOUT: go to IDLE, pulse frame_err, discard partial data.
- Break filter (DROP_BREAK=1):
  - A good 0xF0 sets the break flag and is not pushed.
  - The next good byte is not pushed and clears the flag.
  - 0xE0 is always pushed.
  - Bad frames do not change the flag.
  - With DROP_BREAK=0, every good byte is pushed.
- FIFO:
  - Push occurs in the cycle after the stop-bit fall cycle, so kv rises on the next rising edge. Total latency from the stop-bit pin edge to kv=1 is at most 4 clk.
  - Pop occurs when kr=1 and kv=1; kd shows the next entry (or 0x00) on the following cycle.
  - kr while kv=0 is ignored.
  - Push while full and no pop: byte dropped, ovf pulses 1 cycle, contents unchanged.
  - Push and pop in the same cycle while full: both occur, no ovf, count unchanged.
  - Push and pop in the same cycle while non-empty and not full: count unchanged, order preserved.
  - Read/write pointers wrap modulo FIFO_DEPTH. Count is held in a separate register of width log2(FIFO_DEPTH)+1.
- Reset mid-frame or with a non-empty FIFO clears everything. The next frame must begin with a fresh start bit.
- frame_err and ovf never assert in the same cycle for the same frame. Each is a registered single-cycle pulse.

Test Plan:
- Good frame, kr=0: send 0x1C (data LSB first, parity 0, stop 1) → kv=1, kd=0x1C within 4 clk of the stop edge. Pulse kr → kv=0, kd=0x00.
- Break stripping: send 0x1C, 0xF0, 0x1C, 0xE0 (DROP_BREAK=1) → FIFO holds 0x1C, 0xE0 in that order, with no frame_err. Repeat with DROP_BREAK=0 → four bytes.
- Errors: send 0x12 with wrong parity, then 0x12 with stop=0, then stop toggling ps2_clk after 5 bits for >2000 clk → three frame_err pulses, kv stays 0. The next good 0x12 is delivered.
- Overflow: send 5 good bytes 0x01..0x05 with kr=0 (DEPTH=4) → one ovf pulse on the 5th; then pops return 0x01..0x04, after which kv=0.
- Simultaneous push/pop with FIFO full: hold kr=1 in the push cycle of the 5th byte → no ovf, pops return 0x02..0x05.
- Reset mid-frame: assert rst_n=0 after 4 bits with 2 bytes buffered → kv=0, kd=0x00 immediately. A following complete frame 0x33 is received correctly.
